pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipelined datapath.
//  - Drives the IF/ID register's write-disable (IFID_writeOff) and flush inputs, the PC write-disable,
//    and the ID/EX bubble and hold controls.
//  - Detects load-use hazards, squashes wrong-path instructions on taken branches resolved in EX,
//    and freezes the pipe while data memory is busy, guarded by a watchdog.

---
 rtl/pipeline_hazard_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipe (load-use, branch squash, memory freeze with watchdog).
// Optional feature macro: HAZARD_PERF_CNT_EN enables the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int MAX_STALL = 15,
    parameter int CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [REG_AW-1:0] IFID_Rs,
    input  logic [REG_AW-1:0] IFID_Rt,
    input  logic              IFID_usesRt,
    input  logic              IDEX_MemRead,
    input  logic [REG_AW-1:0] IDEX_Rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              PC_writeOff,
    output logic              IFID_writeOff,
    output logic              IFID_flush,
    output logic              IDEX_bubble,
    output logic              IDEX_writeOff,
    output logic              EXMEM_writeOff,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;
    state_t           state;
    logic [CNT_W-1:0] wd;
    logic [CNT_W-1:0] wd_nxt;
    logic             load_use;
    logic             tmo;
    logic             frz;
    logic             br;
    logic             lu;
    assign load_use = IDEX_MemRead && IDEX_Rt != '0 &&
                      (IDEX_Rt == IFID_Rs || (IFID_usesRt && IDEX_Rt == IFID_Rt));
    assign tmo      = state == TIMEOUT;
    assign frz      = tmo || mem_busy;
    assign br       = !frz && branch_taken;
    assign lu       = !frz && !branch_taken && load_use;
    assign wd_nxt   = state == RUN ? CNT_W'(1) : wd + 1'b1;
    assign PC_writeOff    = Reset_n && (frz || lu);
    assign IFID_writeOff  = Reset_n && (frz || lu);
    assign IFID_flush     = Reset_n && br;
    assign IDEX_bubble    = Reset_n && (br || lu);
    assign IDEX_writeOff  = Reset_n && frz;
    assign EXMEM_writeOff = Reset_n && frz;
    assign stall_timeout  = Reset_n && tmo;
    // State and watchdog: memory freeze counts up until MAX_STALL, then TIMEOUT holds until reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= RUN;
            wd    <= '0;
        end else if (!tmo) begin
            if (mem_busy) begin
                wd    <= wd_nxt;
                state <= wd_nxt >= CNT_W'(MAX_STALL) ? TIMEOUT : MEM_WAIT;
            end else begin
                wd    <= '0;
                state <= RUN;
            end
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters for stalled cycles and branch flushes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((frz || lu) && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (br && flush_count != '1) flush_count <= flush_count + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule
